// File: rtl/scalar_mem_pkg.sv
// Shared types, constants and the round-robin pick function for the scalar
// data memory arbiter and the upcoming vector-bank arbiter.
package scalar_mem_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    // Widest requester vector rr_pick handles; callers zero-extend narrower ones.
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Rotate valid so ptr lands at bit 0, isolate the lowest set bit, then
    // rotate the one-hot result back. Only the low n bits take part.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n = MAX_REQ
    );
        logic [MAX_REQ-1:0] rot;
        logic [MAX_REQ-1:0] first;
        logic [IDX_W-1:0]   idx;
        rot     = '0;
        rr_pick = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < int'(n)) begin
                idx    = IDX_W'((ptr + i) % n);
                rot[i] = valid[idx];
            end
        end
        first = rot & (~rot + 1'b1);
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < int'(n)) begin
                idx          = IDX_W'((ptr + i) % n);
                rr_pick[idx] = first[i];
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo N. Returns a one-hot grant, or zero when nothing is valid.
module rr_priority_picker #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);
    import scalar_mem_pkg::*;

    // Rotate / find-first / unrotate, narrowed back to N requesters.
    always_comb begin
        grant_o = N'(rr_pick(MAX_REQ'(valid_i), 32'(ptr_i), N));
    end

endmodule

// File: rtl/scalar_mem_arbiter.sv
// Shares the single-port scalar data memory between the core MEM stage
// (requester 0) and the vector unit scalar port (requester 1). Round-robin
// grant with an optional bounded lock; read data returns one cycle after issue.
module scalar_mem_arbiter #(
    parameter int N_REQ    = 2,
    parameter int ADDR_W   = scalar_mem_pkg::ADDR_W,
    parameter int DATA_W   = scalar_mem_pkg::DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        REQ_VALID,
    input  logic [N_REQ-1:0]        REQ_WE,
    input  logic [N_REQ-1:0]        REQ_LOCK,
    input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0] REQ_WDATA,
    output logic [N_REQ-1:0]        REQ_READY,
    output logic [N_REQ-1:0]        RSP_VALID,
    output logic [DATA_W-1:0]       RSP_RDATA,
    output logic                    MEM_WE,
    output logic [ADDR_W-1:0]       MEM_A,
    output logic [DATA_W-1:0]       MEM_WD,
    input  logic [DATA_W-1:0]       MEM_RD
);
    import scalar_mem_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    arb_state_t          state_q, state_d;
    ptr_t                rr_ptr_q, rr_ptr_d;
    ptr_t                owner_q, owner_d;
    logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]    rsp_pend_q, rsp_pend_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;

    logic [N_REQ-1:0]    rr_grant;
    logic [N_REQ-1:0]    grant;
    logic                grant_valid;
    ptr_t                g;

    // Successor of a requester index, wrapping at N_REQ.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (int'(p) == N_REQ - 1) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    rr_priority_picker #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .valid_i (REQ_VALID),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant)
    );

    // Grant: round-robin when idle, owner-only when locked, nothing in reset.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        grant = '0;
        g     = '0;
        if (!RST) begin
            if (state_q == IDLE) begin
                grant = rr_grant;
            end else begin
                grant = REQ_VALID & (N_REQ'(1) << owner_q);
            end
        end
        grant_valid = |grant;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g = ptr_t'(i);
            end
        end
    end

    // Memory drive: granted requester's address/data, otherwise hold the last mux value.
    always_comb begin
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        if (grant_valid) begin
            mem_a_d  = REQ_ADDR[int'(g)*ADDR_W +: ADDR_W];
            mem_wd_d = REQ_WDATA[int'(g)*DATA_W +: DATA_W];
        end
        MEM_WE = grant_valid & REQ_WE[g];
        MEM_A  = RST ? '0 : mem_a_d;
        MEM_WD = RST ? '0 : mem_wd_d;
    end

    // Lock FSM next state, pointer update and read-response tagging.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_pend_d = grant & ~REQ_WE;
        if (grant_valid) begin
            case (state_q)
                IDLE: begin
                    if (REQ_LOCK[g]) begin
                        state_d    = LOCKED;
                        owner_d    = g;
                        lock_cnt_d = CNT_W'(1);
                    end else begin
                        rr_ptr_d = ptr_inc(g);
                    end
                end
                LOCKED: begin
                    if (!REQ_LOCK[g] || lock_cnt_q == CNT_W'(LOCK_MAX)) begin
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                        rr_ptr_d   = ptr_inc(owner_q);
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Response outputs: pending pulse pairs with the memory's registered read data.
    always_comb begin
        REQ_READY = grant;
        RSP_VALID = RST ? '0 : rsp_pend_q;
        RSP_RDATA = MEM_RD;
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (RST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rsp_pend_q <= '0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rsp_pend_q <= rsp_pend_d;
            mem_a_q    <= mem_a_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

endmodule

// File: tb/tb_scalar_mem_arbiter.sv
// Self-checking bench for scalar_mem_arbiter: a fixed vector table, directed
// lock / reset sequences and randomized traffic against a behavioural model.
module tb_scalar_mem_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LMAX = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_we;
    logic [AW-1:0]   mem_a;
    logic [DW-1:0]   mem_wd;
    logic [DW-1:0]   mem_rd;

    always #5 clk = ~clk;

    scalar_mem_arbiter #(
        .N_REQ    (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .LOCK_MAX (LMAX)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid),
        .REQ_WE    (req_we),
        .REQ_LOCK  (req_lock),
        .REQ_ADDR  (req_addr),
        .REQ_WDATA (req_wdata),
        .REQ_READY (req_ready),
        .RSP_VALID (rsp_valid),
        .RSP_RDATA (rsp_rdata),
        .MEM_WE    (mem_we),
        .MEM_A     (mem_a),
        .MEM_WD    (mem_wd),
        .MEM_RD    (mem_rd)
    );

    // Single-port memory: synchronous write, registered read, 16 words.
    logic [DW-1:0] dev_mem [0:15];
    always @(posedge clk) begin
        if (mem_we === 1'b1) dev_mem[mem_a[3:0]] <= mem_wd;
        mem_rd <= dev_mem[mem_a[3:0]];
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit            m_locked;
    int            m_owner, m_cnt, m_ptr, m_pend;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] shadow [0:15];
    logic [N-1:0]  last_ready;

    // Who should win this cycle: owner only while locked, else first valid from ptr.
    function automatic int model_pick();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int i = 0; i < N; i++) begin
            int k = (m_ptr + i) % N;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    // One clock with inputs already driven: compare against the model, then advance it.
    task automatic cycle(input string tag);
        int            g;
        logic [N-1:0]  exp_ready, exp_rsp;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        g          = model_pick();
        exp_ready  = (g < 0) ? '0 : N'(1 << g);
        exp_rsp    = (m_pend < 0) ? '0 : N'(1 << m_pend);
        last_ready = req_ready;
        check({tag, ".ready"}, req_ready, exp_ready);
        check({tag, ".rsp_valid"}, rsp_valid, exp_rsp);
        if (m_pend >= 0) check({tag, ".rsp_rdata"}, rsp_rdata, m_pend_data);
        if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            d = req_wdata[g*DW +: DW];
            check({tag, ".mem_we"}, mem_we, req_we[g]);
            check({tag, ".mem_a"}, mem_a, a);
            if (req_we[g]) check({tag, ".mem_wd"}, mem_wd, d);
        end else begin
            check({tag, ".mem_we_idle"}, mem_we, 1'b0);
        end
        m_pend = -1;
        if (g >= 0) begin
            if (req_we[g]) shadow[a[3:0]] = d;
            else begin
                m_pend      = g;
                m_pend_data = shadow[a[3:0]];
            end
            if (!m_locked) begin
                if (req_lock[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_cnt    = 1;
                end else begin
                    m_ptr = (g + 1) % N;
                end
            end else if (!req_lock[g] || m_cnt == LMAX) begin
                m_locked = 1'b0;
                m_cnt    = 0;
                m_ptr    = (m_owner + 1) % N;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One reset cycle with arbitrary request inputs: everything must stay quiet.
    task automatic reset_cycle(input string tag);
        rst = 1'b1;
        drive(2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(15), $urandom_range(15),
              $urandom, $urandom);
        @(negedge clk);
        check({tag, ".rst_ready"}, req_ready, '0);
        check({tag, ".rst_mem_we"}, mem_we, 1'b0);
        check({tag, ".rst_rsp_valid"}, rsp_valid, '0);
        check({tag, ".rst_mem_a"}, mem_a, '0);
        check({tag, ".rst_mem_wd"}, mem_wd, '0);
        m_locked = 1'b0;
        m_ptr    = 0;
        m_cnt    = 0;
        m_pend   = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  v, we, lk;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  exp_ready, exp_rsp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, first_r1;

        // Write then read-after-write, then both requesters contending.
        vecs[0] = '{2'b01, 2'b01, 2'b00, 32'd3, 32'd0, 32'hDEADBEEF, 32'd0, 2'b01, 2'b00, 32'd0};
        vecs[1] = '{2'b10, 2'b00, 2'b00, 32'd0, 32'd3, 32'd0, 32'd0, 2'b10, 2'b00, 32'd0};
        vecs[2] = '{2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b10, 32'hDEADBEEF};
        vecs[3] = '{2'b11, 2'b11, 2'b00, 32'd5, 32'd6, 32'h55, 32'h66, 2'b01, 2'b00, 32'd0};
        vecs[4] = '{2'b11, 2'b11, 2'b00, 32'd5, 32'd6, 32'h55, 32'h66, 2'b10, 2'b00, 32'd0};
        vecs[5] = '{2'b11, 2'b00, 2'b00, 32'd5, 32'd6, 32'd0, 32'd0, 2'b01, 2'b00, 32'd0};
        vecs[6] = '{2'b11, 2'b00, 2'b00, 32'd5, 32'd6, 32'd0, 32'd0, 2'b10, 2'b01, 32'h55};
        vecs[7] = '{2'b11, 2'b00, 2'b00, 32'd5, 32'd6, 32'd0, 32'd0, 2'b01, 2'b10, 32'h66};
        vecs[8] = '{2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b01, 32'h55};
        vecs[9] = '{2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0};

        for (int i = 0; i < 16; i++) shadow[i] = '0;
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_cycle("reset");

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].lk, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d.ready", i), req_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d.rsp_valid", i), rsp_valid, vecs[i].exp_rsp);
            if (vecs[i].exp_rsp != 2'b00)
                check($sformatf("vec%0d.rsp_rdata", i), rsp_rdata, vecs[i].exp_data);
            @(posedge clk);
            #1;
        end

        // Single requester: write A*10 to A = 0..9, read back.
        reset_cycle("single");
        for (int a = 0; a < 10; a++) begin
            drive(2'b01, 2'b01, 2'b00, a, 0, a * 10, 0);
            cycle("single_wr");
        end
        for (int a = 0; a < 10; a++) begin
            drive(2'b01, 2'b00, 2'b00, a, 0, 0, 0);
            cycle("single_rd");
        end
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle("single_drain");

        // Lock: requester 1 holds three writes (LOCK 1,1,0) while requester 0 waits.
        reset_cycle("lock");
        drive(2'b01, 2'b01, 2'b00, 10, 0, 32'hA0, 0);
        cycle("lock_pre");
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b11, {(i < 2) ? 1'b1 : 1'b0, 1'b0}, 11, 12 + i, 32'hB0, 32'hC0 + i);
            cycle("lock_hold");
            check("lock.r1_owns", last_ready, 2'b10);
        end
        drive(2'b11, 2'b11, 2'b00, 11, 15, 32'hB1, 32'hC9);
        cycle("lock_after");
        check("lock.r0_next", last_ready, 2'b01);

        // Forced release: the locking beat plus LOCK_MAX owner beats, then requester 1.
        reset_cycle("force");
        n0       = 0;
        first_r1 = -1;
        for (int i = 0; i < 12; i++) begin
            drive(2'b11, 2'b11, 2'b01, 13, 14, $urandom, $urandom);
            cycle("force");
            if (first_r1 < 0 && last_ready == 2'b01) n0++;
            if (first_r1 < 0 && last_ready == 2'b10) first_r1 = i;
        end
        check("force.owner_beats", 64'(n0), 64'(LMAX + 1));
        check("force.r1_slot", 64'(first_r1), 64'(LMAX + 1));

        // Read-after-write across requesters in consecutive cycles.
        reset_cycle("raw");
        drive(2'b01, 2'b01, 2'b00, 3, 0, 32'hDEADBEEF, 0);
        cycle("raw_wr");
        drive(2'b10, 2'b00, 2'b00, 0, 3, 0, 0);
        cycle("raw_rd");
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle("raw_rsp");

        // Reset one cycle after a read grant drops the response and clears state.
        reset_cycle("rmr");
        drive(2'b01, 2'b00, 2'b00, 3, 0, 0, 0);
        cycle("rmr_rd");
        reset_cycle("rmr");
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle("rmr_after");
        drive(2'b10, 2'b01, 2'b10, 0, 7, 0, 32'h77);
        cycle("rmr_idle");

        // Fill memory, then randomized traffic with occasional resets.
        for (int a = 0; a < 16; a++) begin
            drive(2'b01, 2'b01, 2'b00, a, 0, $urandom, 0);
            cycle("fill");
        end
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) begin
                reset_cycle("rnd");
            end else begin
                drive(2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(15),
                      $urandom_range(15), $urandom, $urandom);
                cycle("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
